// File: rtl/axi_aw_arbiter_if.sv
// AW request/grant bundle between NUM_M masters, the shared AW FIFO and the W-channel mux.
interface axi_aw_arbiter_if #(
    parameter int unsigned NUM_M = 2,
    parameter int unsigned PW    = 45
);
    logic [NUM_M-1:0]    s_awvalid;
    logic [NUM_M*PW-1:0] s_awpayload;
    logic [NUM_M-1:0]    s_awready;
    logic                m_awvalid;
    logic                m_awready;
    logic [PW+3:0]       m_awdata;
    logic [1:0]          w_owner;
    logic                w_owner_vld;
    logic                w_last_done;

    modport slave (
        input  s_awvalid, s_awpayload, m_awready, w_last_done,
        output s_awready, m_awvalid, m_awdata, w_owner, w_owner_vld
    );

    modport master (
        output s_awvalid, s_awpayload, m_awready, w_last_done,
        input  s_awready, m_awvalid, m_awdata, w_owner, w_owner_vld
    );
endinterface

// File: rtl/axi_aw_arbiter.sv
// Shares one AXI AW channel between NUM_M masters and queues grant order for the W mux.
// Define AW_ARB_FIXED_PRIO_EN to replace round-robin with lowest-index-wins priority.
module axi_aw_arbiter #(
    parameter int unsigned NUM_M     = 2,
    parameter int unsigned PW        = 45,
    parameter int unsigned ORD_DEPTH = 4
) (
    input logic             clk,
    input logic             rst_n,   // active-high synchronous reset
    axi_aw_arbiter_if.slave bus
);
    localparam int unsigned PTR_W = (ORD_DEPTH > 1) ? $clog2(ORD_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(ORD_DEPTH + 1);

    logic             lock_q, lock_d;
    logic [1:0]       locked_idx_q, locked_idx_d;
`ifndef AW_ARB_FIXED_PRIO_EN
    logic [1:0]       rr_ptr_q, rr_ptr_d;
`endif
    logic [1:0]       ord_mem_q [ORD_DEPTH];
    logic [1:0]       ord_mem_d [ORD_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [1:0]    grant;
    logic          found, sel_valid, arb_valid, ord_full, ord_empty, owner_vld, push, pop;
    logic [PW-1:0] sel_payload;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(ORD_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        grant = '0;
        found = 1'b0;
        if (lock_q) begin
            grant = locked_idx_q;
        end else begin
`ifdef AW_ARB_FIXED_PRIO_EN
            for (int k = 0; k < int'(NUM_M); k++) begin
                if (!found && bus.s_awvalid[k]) begin
                    grant = 2'(k);
                    found = 1'b1;
                end
            end
`else
            grant = rr_ptr_q;
            // Scan from rr_ptr upwards, wrapping at NUM_M.
            for (int i = 0; i < int'(NUM_M); i++) begin
                for (int k = 0; k < int'(NUM_M); k++) begin
                    if (!found && bus.s_awvalid[k] &&
                        k == (int'(rr_ptr_q) + i) % int'(NUM_M)) begin
                        grant = 2'(k);
                        found = 1'b1;
                    end
                end
            end
`endif
        end
    end

    always_comb begin
        sel_valid   = 1'b0;
        sel_payload = '0;
        for (int k = 0; k < int'(NUM_M); k++) begin
            if (grant == 2'(k)) begin
                sel_valid   = bus.s_awvalid[k];
                sel_payload = bus.s_awpayload[k*PW +: PW];
            end
        end
    end

    assign ord_full  = (count_q == CNT_W'(ORD_DEPTH));
    assign ord_empty = (count_q == '0);
    assign arb_valid = (lock_q ? sel_valid : |bus.s_awvalid) & ~ord_full & ~rst_n;
    assign push      = arb_valid & bus.m_awready;
    assign pop       = bus.w_last_done & ~ord_empty & ~rst_n;
    assign owner_vld = ~rst_n & ~ord_empty;

    always_comb begin
        bus.m_awvalid   = arb_valid;
        bus.m_awdata    = rst_n ? '0 : {2'b00, grant, sel_payload};
        bus.s_awready   = '0;
        for (int k = 0; k < int'(NUM_M); k++) begin
            bus.s_awready[k] = ~rst_n & (grant == 2'(k)) & bus.m_awready & ~ord_full;
        end
        bus.w_owner_vld = owner_vld;
        bus.w_owner     = owner_vld ? ord_mem_q[rd_ptr_q] : 2'b00;
    end

    always_comb begin
        lock_d       = lock_q;
        locked_idx_d = locked_idx_q;
`ifndef AW_ARB_FIXED_PRIO_EN
        rr_ptr_d     = rr_ptr_q;
`endif
        ord_mem_d    = ord_mem_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;

        if (push) begin
            lock_d = 1'b0;
`ifndef AW_ARB_FIXED_PRIO_EN
            rr_ptr_d = (grant == 2'(NUM_M - 1)) ? 2'd0 : grant + 2'd1;
`endif
        end else if (arb_valid) begin
            // Valid without accept: pin the grant so the payload stays stable.
            lock_d       = 1'b1;
            locked_idx_d = grant;
        end

        if (push) begin
            ord_mem_d[wr_ptr_q] = grant;
            wr_ptr_d            = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            lock_q       <= 1'b0;
            locked_idx_q <= '0;
`ifndef AW_ARB_FIXED_PRIO_EN
            rr_ptr_q     <= '0;
`endif
            for (int i = 0; i < int'(ORD_DEPTH); i++) begin
                ord_mem_q[i] <= '0;
            end
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
        end else begin
            lock_q       <= lock_d;
            locked_idx_q <= locked_idx_d;
`ifndef AW_ARB_FIXED_PRIO_EN
            rr_ptr_q     <= rr_ptr_d;
`endif
            ord_mem_q    <= ord_mem_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
        end
    end
endmodule
